// File: rtl/imm_ext_ctrl.sv
// imm_ext_ctrl: decode-stage immediate extension with a small output FIFO.
//
// Each accepted 32-bit instruction word is classified by opcode. The matching
// immediate extension (sign, zero, LUI shift, branch offset or jump target)
// is computed combinationally and stored in a DEPTH-entry FIFO. The FIFO lets
// a stalled ID/EX stage hold off without losing words. Unsupported opcodes
// are flagged and counted.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   flush                 synchronous flush; drops buffered words, blocks input
//   in_valid/in_ready     input handshake; in_instr is the instruction word
//   out_valid/out_ready   output handshake for the head entry
//   out_imm/out_mode      head immediate and mode (0 NONE .. 5 JUMP)
//   out_illegal           head opcode unsupported
//   illegal_cnt           saturating count of accepted illegal words

// Combinational opcode classifier and immediate extender.
module imm_ext_dec (
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output logic [2:0]  mode,
  output logic        illegal
);
  localparam logic [2:0] M_NONE = 3'd0, M_SIGN = 3'd1, M_ZERO = 3'd2,
                         M_LUI  = 3'd3, M_BR   = 3'd4, M_JUMP = 3'd5;

  logic [5:0]  op;
  logic [15:0] i16;
  logic [25:0] t26;

  assign op  = instr[31:26];
  assign i16 = instr[15:0];
  assign t26 = instr[25:0];

  always_comb begin
    imm     = '0;
    mode    = M_NONE;
    illegal = 1'b0;
    casez (op)
      6'b000000: ;                                   // R-type: no immediate
      6'b0010??,                                     // ADDI/ADDIU/SLTI/SLTIU
      6'b10????: begin                               // loads and stores
        mode = M_SIGN;
        imm  = {{16{i16[15]}}, i16};
      end
      6'b001100, 6'b001101, 6'b001110: begin         // ANDI/ORI/XORI
        mode = M_ZERO;
        imm  = {16'h0, i16};
      end
      6'b001111: begin                               // LUI
        mode = M_LUI;
        imm  = {i16, 16'h0};
      end
      6'b00010?: begin                               // BEQ/BNE word offset
        mode = M_BR;
        imm  = {{14{i16[15]}}, i16, 2'b00};
      end
      6'b00001?: begin                               // J/JAL
        mode = M_JUMP;
        imm  = {4'h0, t26, 2'b00};
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

module imm_ext_ctrl #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_imm,
  output logic [2:0]       out_mode,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  mode;
    logic        illegal;
  } ent_t;

  ent_t          mem [DEPTH];
  ent_t          dec_e, head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  logic [31:0] dec_imm;
  logic [2:0]  dec_mode;
  logic        dec_ill;

  imm_ext_dec u_dec (
    .instr  (in_instr),
    .imm    (dec_imm),
    .mode   (dec_mode),
    .illegal(dec_ill)
  );

  assign dec_e = '{imm: dec_imm, mode: dec_mode, illegal: dec_ill};

  assign in_ready  = (count < FULL) & ~flush;
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;   // never true during flush
  assign pop       = out_valid & out_ready & ~flush;

  // Head comes straight from the storage flops; gated to zero when empty.
  assign head        = mem[rd_ptr];
  assign out_imm     = out_valid ? head.imm     : '0;
  assign out_mode    = out_valid ? head.mode    : '0;
  assign out_illegal = out_valid ? head.illegal : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec_e;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Counts at accept time, so flushed illegal words are still counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      illegal_cnt <= '0;
    else if (push && dec_ill && (illegal_cnt != {CNT_W{1'b1}}))
      illegal_cnt <= illegal_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_imm_ext_ctrl.sv
module tb_imm_ext_ctrl;
  localparam logic [2:0] M_NONE = 3'd0, M_SIGN = 3'd1, M_ZERO = 3'd2,
                         M_LUI  = 3'd3, M_BR   = 3'd4, M_JUMP = 3'd5;

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  mode;
    logic        ill;
  } exp_t;

  logic        clk = 0, rst_n = 0, flush = 0;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [31:0] in_instr = '0, out_imm;
  logic [2:0]  out_mode;
  logic        out_illegal;
  logic [15:0] illegal_cnt;

  // small-counter instance for saturation
  logic        flush2 = 0, in_valid2 = 0, in_ready2, out_valid2, out_ready2 = 1;
  logic [31:0] in_instr2 = '0, out_imm2;
  logic [2:0]  out_mode2;
  logic        out_illegal2;
  logic [1:0]  illegal_cnt2;

  always #5 clk = ~clk;

  imm_ext_ctrl #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_mode(out_mode), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  imm_ext_ctrl #(.DEPTH(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_instr(in_instr2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_imm(out_imm2),
    .out_mode(out_mode2), .out_illegal(out_illegal2), .illegal_cnt(illegal_cnt2)
  );

  int    checks = 0, errors = 0;
  exp_t  q[$];
  exp_t  cur_exp = '0;
  logic [15:0] exp_cnt = '0;
  logic  stall_prev = 0;
  exp_t  stall_head = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, req, $time);
    end
  endtask

  // Scoreboard monitor: records accepts, checks pops and buffer state.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_cnt    = '0;
      stall_prev = 0;
    end else begin
      chk("occupancy", {63'd0, out_valid}, {63'd0, q.size() != 0});
      chk("illegal_cnt", {48'd0, illegal_cnt}, {48'd0, exp_cnt});
      if (!out_valid) chk("empty_zero", {28'd0, out_imm, out_mode, out_illegal}, 64'd0);
      if (stall_prev && out_valid)
        chk("stall_stable", {28'd0, out_imm, out_mode, out_illegal}, {28'd0, stall_head});
      stall_prev = out_valid && !out_ready && !flush;
      stall_head = {out_imm, out_mode, out_illegal};
      if (flush) begin
        chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
        q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("spurious_pop", {63'd0, out_valid}, 64'd0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("head", {28'd0, out_imm, out_mode, out_illegal}, {28'd0, e});
          end
        end
        if (in_valid && in_ready) begin
          q.push_back(cur_exp);
          if (cur_exp.ill && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
      end
    end
  end

  // Offer a word until accepted; returns just after the accept edge.
  task automatic send(input logic [31:0] w, input logic [31:0] imm,
                      input logic [2:0] md, input logic il);
    bit ok;
    ok       = 0;
    in_instr = w;
    cur_exp  = {imm, md, il};
    in_valid = 1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=no_accept required=accept word=%h", w);
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #23 rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;

    // Basic modes, one-cycle latency from empty
    send(32'h2008FFFF, 32'hFFFFFFFF, M_SIGN, 0);
    chk("latency", {63'd0, out_valid}, 64'd1);
    send(32'h3108FFFF, 32'h0000FFFF, M_ZERO, 0);
    send(32'h3C081234, 32'h12340000, M_LUI, 0);
    send(32'h1000FFFE, 32'hFFFFFFF8, M_BR, 0);
    send(32'h08100004, 32'h00400010, M_JUMP, 0);
    send(32'h00851020, 32'h00000000, M_NONE, 0);
    repeat (3) @(posedge clk); #1;

    // Stall: two accepted, third blocked until a pop frees a slot
    out_ready = 0;
    send(32'h24098000, 32'hFFFF8000, M_SIGN, 0);
    send(32'h342100FF, 32'h000000FF, M_ZERO, 0);
    @(negedge clk);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    in_instr = 32'h8C220010;
    cur_exp  = {32'h00000010, M_SIGN, 1'b0};
    in_valid = 1;
    repeat (3) @(negedge clk);
    chk("full_hold", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    out_ready = 1;
    send(32'h8C220010, 32'h00000010, M_SIGN, 0);
    repeat (4) @(posedge clk); #1;

    // Illegal opcodes
    send(32'hFC000000, 32'h0, M_NONE, 1);
    @(negedge clk);
    chk("illegal_flag", {63'd0, out_illegal}, 64'd1);
    @(posedge clk); #1;
    send(32'h18000000, 32'h0, M_NONE, 1);
    repeat (3) @(posedge clk); #1;
    chk("illegal_cnt_2", {48'd0, illegal_cnt}, 64'd2);

    // Flush while full with a word offered
    out_ready = 0;
    send(32'h38431234, 32'h00001234, M_ZERO, 0);
    send(32'h14430001, 32'h00000004, M_BR, 0);
    in_instr = 32'hFC000000;
    cur_exp  = {32'h0, M_NONE, 1'b1};
    in_valid = 1;
    flush    = 1;
    @(posedge clk); #1;
    flush     = 0;
    out_ready = 1;
    @(negedge clk);
    chk("flush_empty", {63'd0, out_valid}, 64'd0);
    chk("flush_cnt", {48'd0, illegal_cnt}, 64'd2);
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    chk("post_flush_out", {63'd0, out_valid}, 64'd1);
    repeat (3) @(posedge clk); #1;

    // Asynchronous reset with two buffered entries
    out_ready = 0;
    send(32'h2008FFFF, 32'hFFFFFFFF, M_SIGN, 0);
    send(32'h3108FFFF, 32'h0000FFFF, M_ZERO, 0);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_cnt", {48'd0, illegal_cnt}, 64'd0);
    @(posedge clk); #3;
    rst_n     = 1;
    out_ready = 1;
    @(negedge clk);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    send(32'h3C01ABCD, 32'hABCD0000, M_LUI, 0);
    chk("arst_latency", {63'd0, out_valid}, 64'd1);
    repeat (3) @(posedge clk); #1;

    // Counter saturation on a 2-bit instance
    in_instr2 = 32'hFC000000;
    in_valid2 = 1;
    repeat (2) @(posedge clk); #1;
    chk("sat_cnt_2", {62'd0, illegal_cnt2}, 64'd2);
    repeat (3) @(posedge clk); #1;
    chk("sat_cnt_max", {62'd0, illegal_cnt2}, 64'd3);
    in_valid2 = 0;
    chk("sat_head", {27'd0, out_valid2, out_imm2, out_mode2, out_illegal2},
        {27'd0, 1'b1, 32'h0, 3'd0, 1'b1});
    chk("sat_in_ready", {63'd0, in_ready2}, 64'd1);
    repeat (2) @(posedge clk); #1;
    chk("sat_hold", {62'd0, illegal_cnt2}, 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imm_ext_ctrl.md
Name: imm_ext_ctrl

Overview:
Sequencer and buffer for the immediate-extension datapath in the decode stage. It accepts 32-bit instruction words on a valid/ready handshake and selects the extension mode from the opcode: sign, zero, LUI-shift, branch-offset or jump-target. It computes the 32-bit extended immediate and holds results in a 2-entry output buffer so a stalled downstream stage does not lose words. It sits between instruction fetch/decode and the ID/EX register, and also flags and counts unsupported opcodes.

Parameters:
DEPTH, 2, output buffer entries (power of 2, >=2)
CNT_W, 16, width of the saturating illegal-opcode counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush; discards buffered and incoming words
in_valid  input  1  instruction word present
in_ready  output  1  block can accept a word this cycle
in_instr  input  32  instruction word; opcode = [31:26], imm16 = [15:0], target26 = [25:0]
out_valid  output  1  head buffer entry valid
out_ready  input  1  consumer takes head entry this cycle
out_imm  output  32  extended immediate of head entry
out_mode  output  3  mode of head entry: 0 NONE, 1 SIGN, 2 ZERO, 3 LUI, 4 BRANCH, 5 JUMP
out_illegal  output  1  head entry's opcode unsupported (out_imm = 0, mode NONE)
illegal_cnt  output  CNT_W  saturating count of accepted illegal words

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset: buffer empty, out_valid=0, out_imm=0, out_mode=0, out_illegal=0, illegal_cnt=0, in_ready=1 once rst_n deasserts. Reset mid-transfer drops all entries immediately.
- Opcode decode:
  - 000000 (R-type): NONE, imm=0, legal.
  - 001000-001011 (ADDI/ADDIU/SLTI/SLTIU) and 100xxx, 101xxx (loads/stores): SIGN, imm = {16{imm16[15]}, imm16}.
  - 001100-001110 (ANDI/ORI/XORI): ZERO, imm = {16'h0, imm16}.
  - 001111 (LUI): LUI, imm = {imm16, 16'h0}.
  - 000100, 000101 (BEQ/BNE): BRANCH, imm = {14{imm16[15]}, imm16, 2'b00}; result truncated to 32 bits.
  - 000010, 000011 (J/JAL): JUMP, imm = {4'h0, target26, 2'b00}.
  - All other opcodes: illegal=1, mode NONE, imm=0.
- Extension is computed combinationally at accept and stored in the buffer entry with mode and illegal.
- Handshake:
  - A push occurs when in_valid & in_ready. A pop occurs when out_valid & out_ready.
  - in_ready = (count < DEPTH) & ~flush.
  - out_valid = (count != 0).
  - Head outputs are registered and stable while out_valid=1 and out_ready=0.
- Latency: word accepted at edge N is visible on out_* after edge N (1 cycle) when the buffer was empty.
- Ordering is strict FIFO. Read and write pointers wrap modulo DEPTH.
- Simultaneous push and pop:
  - Buffer non-empty and not full: count unchanged, both pointers advance.
  - Buffer full: in_ready=0, so pop only.
  - Buffer empty: push only.
- Outputs when empty: out_imm, out_mode and out_illegal return to 0 when the buffer is empty.
- flush: at the edge, count becomes 0 and out_valid=0 next cycle. No push occurs that cycle (in_ready=0). A pop in the same cycle is discarded. illegal_cnt is not cleared by flush.
- illegal_cnt:
  - Increments by 1 per accepted illegal word, including words later flushed.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.
- in_valid with in_ready=0: the word is not taken. The producer holds it; no state change.

Test Plan:
- Empty buffer, out_ready=1; push 0x2008FFFF, 0x3108FFFF, 0x3C081234 on consecutive cycles -> outputs one cycle later in order: 0xFFFFFFFF/SIGN, 0x0000FFFF/ZERO, 0x12340000/LUI.
- Push 0x1000FFFE (BEQ) then 0x0810_0004 (J) -> 0xFFFFFFF8/BRANCH, then 0x00400010/JUMP. Push 0x00851020 (R-type) -> 0x00000000/NONE, out_illegal=0.
- out_ready=0; offer 3 words back-to-back -> 2 accepted, in_ready=0 from the cycle after the second accept. Raise out_ready -> third word accepted on the first pop cycle, FIFO order preserved, out_* stable while stalled.
- Push 0xFC000000 (opcode 111111) -> out_illegal=1, out_imm=0, illegal_cnt=1. Force counter near 0xFFFF and push 2 more illegal words -> illegal_cnt holds at 0xFFFF.
- Buffer full plus in_valid=1; assert flush for 1 cycle -> next cycle out_valid=0, count=0, no word accepted, illegal_cnt unchanged, normal operation the cycle after.
- Buffer holding 2 entries; drop rst_n asynchronously mid-cycle -> out_valid=0 and illegal_cnt=0 immediately. After release, in_ready=1 and the first push produces output after 1 cycle.
